// File: rtl/arty_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arty_uart_pkg
// Description : Shared UART state encoding and bit-timing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package arty_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clks_per_bit(clk_hz, baud) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fabric.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fabric
// Description : 8N1 UART receiver with valid/ready byte hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fabric
    import arty_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       usb_uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned C_CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned C_HALF_BIT     = half_bit(CLK_HZ, BAUD);
    localparam int unsigned C_CNT_W        = $clog2(C_CLKS_PER_BIT);
    localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(C_CLKS_PER_BIT - 1);
    localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(C_HALF_BIT - 1);

    logic               w_rxd;
    logic               w_fall;
    logic               r_rxd_prev;
    logic [1:0]         r_settle;
    uart_state_e        r_state;
    uart_state_e        w_state_next;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               w_stop_ok;
    logic               w_stop_bad;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (sys_clock),
        .rst (reset),
        .i_d (usb_uart_rxd),
        .o_q (w_rxd)
    );

    // The synchronizer shows its reset value for two cycles after release, so
    // the edge history is held low until real line samples have arrived.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_settle   <= 2'b00;
            r_rxd_prev <= 1'b0;
        end else begin
            r_settle   <= {r_settle[0], 1'b1};
            r_rxd_prev <= w_rxd & r_settle[1];
        end
    end

    assign w_fall = r_rxd_prev & ~w_rxd;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + C_CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok      = 1'b0;
        w_stop_bad     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next     = '0;
                w_bit_idx_next = '0;
                if (w_fall) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == C_HALF_LAST) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = w_rxd ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rxd, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (w_rxd) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_next = '0;
                if (w_rxd) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A held byte is only replaced when the consumer takes it in the same cycle.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_stop_ok && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else begin
                if (w_stop_ok) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && rx_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_fabric.md
UART_RX_FABRIC -- requirements
Module: uart_rx_fabric

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, is the sys_clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, is the line rate in bits/s.
REQ-003 Port sys_clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port usb_uart_rxd, input, 1 bit: asynchronous serial line, 8N1 framing, idle high.
REQ-006 Port rx_data, output, 8 bits: last accepted byte.
REQ-007 Port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 Port rx_ready, input, 1 bit: the consumer takes the byte this cycle when rx_valid=1.
REQ-009 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped.
REQ-011 Port busy, output, 1 bit: high whenever the state machine is not IDLE.

Function
REQ-012 The block SHALL pass usb_uart_rxd through a 2-flop synchronizer; the synchronizer flops reset to 1; all later logic uses only the synchronized value.
REQ-013 The block SHALL use CLKS_PER_BIT = CLK_HZ/BAUD, truncated (868 at the defaults), and HALF_BIT = CLKS_PER_BIT/2 (434).
REQ-014 The block SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE -> START: on a synchronized 1->0 transition; the bit counter is cleared.
REQ-016 START: after HALF_BIT cycles, if the line is 0, go to DATA with bit index 0; if it is 1, treat it as a glitch and return to IDLE with no output activity.
REQ-017 DATA: sample once every CLKS_PER_BIT cycles; shift LSB first; after the 8th sample, go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample the line.
  - Sample 1: deliver the byte and return to IDLE on the next cycle, so back-to-back frames are supported.
  - Sample 0: pulse frame_err, discard the byte and go to BREAK.
REQ-019 BREAK: wait until the synchronized line is 1, then go to IDLE.
REQ-020 Delivery when rx_valid=0, or when rx_valid=1 and rx_ready=1 in the same cycle: load rx_data and set rx_valid=1 on the next cycle, with no overrun.
REQ-021 Delivery when rx_valid=1 and rx_ready=0: keep the old rx_data and rx_valid, drop the new byte and pulse overrun.
REQ-022 rx_valid SHALL stay high, with rx_data stable, until a cycle with rx_ready=1; it clears on the following cycle unless REQ-020 reloads it.
REQ-023 rx_ready while rx_valid=0 SHALL have no effect.
REQ-024 Latency: rx_valid SHALL rise exactly 1 cycle after the stop-bit sample cycle.
  - The stop-bit sample falls at 2 + HALF_BIT + 9*CLKS_PER_BIT cycles after the pin falls, within ±1 cycle of synchronizer alignment.
REQ-025 The baud counter SHALL count from 0 to CLKS_PER_BIT-1 and wrap; its width is $clog2(CLKS_PER_BIT).

Reset
REQ-026 In any reset cycle, including mid-frame, the block SHALL:
  - set state to IDLE;
  - clear the counters and the shift register;
  - set rx_data=0x00 and rx_valid=0;
  - set frame_err=0, overrun=0 and busy=0.
REQ-027 After reset, a new frame SHALL be recognized only from a fresh synchronized 1->0 edge; a line held low through reset release SHALL NOT start a frame.

Structure
REQ-028 The state enumeration and the function computing CLKS_PER_BIT/HALF_BIT SHALL live in the shared package arty_uart_pkg, so a future uart_tx_fabric can reuse them.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with reset value as a parameter; everything else stays in uart_rx_fabric.

Verification
REQ-030 Single byte: send 0x55 at 115200 with rx_ready=1 -> one rx_valid pulse, rx_data=0x55, frame_err=0, rx_valid rise within 2+434+9*868+1 ±1 cycles of the pin falling.
REQ-031 Back-to-back frames: send 0xA5, 0x00 and 0xFF with no idle gap, rx_ready=1 -> three bytes delivered in that order, no errors.
REQ-032 Overrun: send 0x12 then 0x34 with rx_ready=0 -> rx_data stays 0x12 and rx_valid stays 1, one overrun pulse; raising rx_ready then gives one consume, rx_valid=0, and 0x34 never appears.
REQ-033 Glitch and framing:
  - A 200-cycle low pulse -> busy returns to 0 with no rx_valid.
  - Frame 0x3C with the stop bit forced low -> one frame_err pulse, no rx_valid, state BREAK until the line goes high.
REQ-034 Reset mid-frame: assert reset for 1 cycle at bit 4 of 0x81 -> all outputs return to reset values, the rest of that frame produces no rx_valid, and the next frame 0x7E is received correctly.
